bp_cache_miss_responder: RTL

- LCE-side responder for the core's cache-service interface.
- Accepts one I$ or D$ miss or uncached request with its metadata, and issues commands to a backing memory port.
- Returns fills through the data/tag/stat mem packet ports, then pulses req_complete.
- Drives the credits_full/credits_empty flow-control pair back to the core.

---
 rtl/bp_cache_miss_responder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_cache_miss_responder.sv
// LCE-side cache miss / uncached request responder driving a credit-tracked backing memory port.
// Optional: define BP_MISS_RESPONDER_WRITEBACK_EN to write dirty victims back before a refill.
module bp_cache_miss_responder_chk
  #(parameter int cred_width_p = 3)
  (input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    yumi_i,
   input  logic [cred_width_p-1:0] count_i);

  // A memory response may only retire a command that is actually outstanding.
  a_no_yumi_at_zero: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> (count_i != {cred_width_p{1'b0}}));

endmodule

module bp_cache_miss_responder
  #(parameter int paddr_width_p   = 40,
    parameter int ptag_width_p    = 28,
    parameter int sets_p          = 64,
    parameter int assoc_p         = 8,
    parameter int dword_width_p   = 64,
    parameter int block_width_p   = 512,
    parameter int credits_p       = 4,
    localparam int lg_sets_lp     = $clog2(sets_p),
    localparam int lg_assoc_lp    = $clog2(assoc_p),
    localparam int block_bytes_lp = block_width_p / 8,
    localparam int offset_w_lp    = $clog2(block_bytes_lp),
    localparam int cred_w_lp      = $clog2(credits_p + 1))
  (input  logic                                          clk_i,
   input  logic                                          reset_n_i,
   input  logic [2+paddr_width_p+dword_width_p-1:0]      cache_req_i,
   input  logic                                          cache_req_v_i,
   output logic                                          cache_req_ready_o,
   input  logic [lg_assoc_lp:0]                          cache_req_metadata_i,
   input  logic                                          cache_req_metadata_v_i,
   output logic                                          cache_req_complete_o,
   output logic                                          credits_full_o,
   output logic                                          credits_empty_o,
   output logic [2+lg_sets_lp+lg_assoc_lp+block_width_p-1:0]  data_mem_pkt_o,
   output logic                                          data_mem_pkt_v_o,
   input  logic                                          data_mem_pkt_ready_i,
   input  logic [block_width_p-1:0]                      data_mem_i,
   output logic [2+lg_sets_lp+lg_assoc_lp+2+ptag_width_p-1:0] tag_mem_pkt_o,
   output logic                                          tag_mem_pkt_v_o,
   input  logic                                          tag_mem_pkt_ready_i,
   input  logic [ptag_width_p-1:0]                       tag_mem_i,
   output logic [2+lg_sets_lp+lg_assoc_lp-1:0]           stat_mem_pkt_o,
   output logic                                          stat_mem_pkt_v_o,
   input  logic                                          stat_mem_pkt_ready_i,
   output logic [2+paddr_width_p+block_width_p-1:0]      mem_cmd_o,
   output logic                                          mem_cmd_v_o,
   input  logic                                          mem_cmd_ready_i,
   input  logic [block_width_p:0]                        mem_resp_i,
   input  logic                                          mem_resp_v_i,
   output logic                                          mem_resp_yumi_o);

  localparam int cmd_w_lp  = 2 + paddr_width_p + block_width_p;
  localparam int dpkt_w_lp = 2 + lg_sets_lp + lg_assoc_lp + block_width_p;
  localparam int tpkt_w_lp = 2 + lg_sets_lp + lg_assoc_lp + 2 + ptag_width_p;
  localparam int spkt_w_lp = 2 + lg_sets_lp + lg_assoc_lp;
  localparam logic [cred_w_lp-1:0] credits_lp = cred_w_lp'(credits_p);

  localparam logic [1:0] MSG_UC_STORE = 2'd3;
  localparam logic [1:0] MEM_READ = 2'd0, MEM_WRITE_LINE = 2'd1, MEM_UC_READ = 2'd2, MEM_UC_WRITE = 2'd3;
  localparam logic [1:0] DATA_WRITE_LINE = 2'd0, DATA_READ_LINE = 2'd1, DATA_UC_RETURN = 2'd2;
  localparam logic [1:0] TAG_SET = 2'd0, TAG_READ = 2'd2;
  localparam logic [1:0] STAT_SET_LRU = 2'd0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_META = 4'd1,
    S_MEM_CMD   = 4'd2,
    S_MEM_RESP  = 4'd3,
    S_FILL_DATA = 4'd4,
    S_FILL_TAG  = 4'd5,
    S_FILL_STAT = 4'd6,
    S_UC_RET    = 4'd7,
    S_COMPLETE  = 4'd8
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
    , S_WB_TAG  = 4'd9,
    S_WB_DATA   = 4'd10,
    S_WB_CMD    = 4'd11
`endif
  } state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  req_type_q, req_type_d;
  logic [paddr_width_p-1:0]    req_addr_q, req_addr_d;
  logic [dword_width_p-1:0]    req_data_q, req_data_d;
  logic [lg_assoc_lp-1:0]      way_q, way_d;
  logic [cmd_w_lp-1:0]         cmd_q, cmd_d;
  logic [dpkt_w_lp-1:0]        dpkt_q, dpkt_d;
  logic [tpkt_w_lp-1:0]        tpkt_q, tpkt_d;
  logic [spkt_w_lp-1:0]        spkt_q, spkt_d;
  logic                        cmd_v_q, cmd_v_d, dpkt_v_q, dpkt_v_d;
  logic                        tpkt_v_q, tpkt_v_d, spkt_v_q, spkt_v_d;
  logic                        complete_q, complete_d, ready_q, ready_d;
  logic [cred_w_lp-1:0]        count_q, count_d;
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
  logic [ptag_width_p-1:0]     wb_tag_q, wb_tag_d;
  logic                        rd_tag_q, rd_tag_d, rd_data_q, rd_data_d;
`endif

  logic [1:0]                  req_type_s;
  logic [paddr_width_p-1:0]    req_addr_s;
  logic [dword_width_p-1:0]    req_data_s;
  logic [lg_assoc_lp-1:0]      meta_way_s;
  logic                        meta_dirty_s;
  logic [lg_sets_lp-1:0]       idx_s;
  logic [ptag_width_p-1:0]     tag_s;
  logic [paddr_width_p-1:0]    line_addr_s;
  logic [block_width_p-1:0]    resp_data_s;
  logic [1:0]                  fill_state_s;
  logic [cmd_w_lp-1:0]         miss_cmd_s, uc_load_cmd_s;
  logic                        is_miss_s, resp_ack_s, resp_read_s, yumi_s;
  logic                        req_hs_s, cmd_hs_s, dpkt_hs_s, tpkt_hs_s, spkt_hs_s;

  assign req_type_s    = cache_req_i[2+paddr_width_p+dword_width_p-1 -: 2];
  assign req_addr_s    = cache_req_i[dword_width_p +: paddr_width_p];
  assign req_data_s    = cache_req_i[dword_width_p-1:0];
  assign meta_way_s    = cache_req_metadata_i[lg_assoc_lp:1];
  assign meta_dirty_s  = cache_req_metadata_i[0];

  assign idx_s         = req_addr_q[offset_w_lp +: lg_sets_lp];
  assign tag_s         = req_addr_q[paddr_width_p-1 -: ptag_width_p];
  assign line_addr_s   = {req_addr_q[paddr_width_p-1:offset_w_lp], {offset_w_lp{1'b0}}};
  assign is_miss_s     = ~req_type_q[1];
  assign fill_state_s  = req_type_q[0] ? 2'b11 : 2'b01;
  assign miss_cmd_s    = {MEM_READ, line_addr_s, {block_width_p{1'b0}}};
  assign uc_load_cmd_s = {MEM_UC_READ, req_addr_q, {block_width_p{1'b0}}};

  assign resp_ack_s    = mem_resp_i[block_width_p];
  assign resp_data_s   = mem_resp_i[block_width_p-1:0];
  // Write acks retire in any state; read data only when the FSM is waiting for it.
  assign yumi_s        = mem_resp_v_i & (resp_ack_s | (state_q == S_MEM_RESP));
  assign resp_read_s   = mem_resp_v_i & ~resp_ack_s & (state_q == S_MEM_RESP);

  assign req_hs_s      = cache_req_v_i & ready_q;
  assign cmd_hs_s      = cmd_v_q & mem_cmd_ready_i;
  assign dpkt_hs_s     = dpkt_v_q & data_mem_pkt_ready_i;
  assign tpkt_hs_s     = tpkt_v_q & tag_mem_pkt_ready_i;
  assign spkt_hs_s     = spkt_v_q & stat_mem_pkt_ready_i;

`ifndef BP_MISS_RESPONDER_WRITEBACK_EN
  logic unused_wb_s;
  assign unused_wb_s = ^{tag_mem_i, data_mem_i, meta_dirty_s};
`endif

  // Next-state, next-output and credit computation.
  always_comb begin
    state_d    = state_q;
    req_type_d = req_type_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    way_d      = way_q;
    cmd_d      = cmd_q;
    cmd_v_d    = cmd_v_q;
    dpkt_d     = dpkt_q;
    dpkt_v_d   = dpkt_v_q;
    tpkt_d     = tpkt_q;
    tpkt_v_d   = tpkt_v_q;
    spkt_d     = spkt_q;
    spkt_v_d   = spkt_v_q;
    complete_d = 1'b0;
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
    wb_tag_d   = wb_tag_q;
    rd_tag_d   = 1'b0;
    rd_data_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_hs_s) begin
          req_type_d = req_type_s;
          req_addr_d = req_addr_s;
          req_data_d = req_data_s;
          if (req_type_s == MSG_UC_STORE) begin
            state_d = S_MEM_CMD;
            cmd_v_d = 1'b1;
            cmd_d   = {MEM_UC_WRITE, req_addr_s, {(block_width_p-dword_width_p){1'b0}}, req_data_s};
          end else begin
            state_d = S_WAIT_META;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_META: begin
        if (cache_req_metadata_v_i) begin
          way_d = meta_way_s;
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
          if (is_miss_s && meta_dirty_s) begin
            state_d  = S_WB_TAG;
            tpkt_v_d = 1'b1;
            tpkt_d   = {TAG_READ, idx_s, meta_way_s, 2'b00, {ptag_width_p{1'b0}}};
          end else begin
            state_d = S_MEM_CMD;
            cmd_v_d = 1'b1;
            cmd_d   = is_miss_s ? miss_cmd_s : uc_load_cmd_s;
          end
`else
          state_d = S_MEM_CMD;
          cmd_v_d = 1'b1;
          cmd_d   = is_miss_s ? miss_cmd_s : uc_load_cmd_s;
`endif
        end else begin
          state_d = S_WAIT_META;
        end
      end
      S_MEM_CMD: begin
        if (cmd_hs_s) begin
          cmd_v_d = 1'b0;
          if (req_type_q == MSG_UC_STORE) begin
            state_d    = S_COMPLETE;
            complete_d = 1'b1;
          end else begin
            state_d = S_MEM_RESP;
          end
        end else begin
          state_d = S_MEM_CMD;
        end
      end
      S_MEM_RESP: begin
        if (resp_read_s) begin
          dpkt_v_d = 1'b1;
          if (is_miss_s) begin
            state_d = S_FILL_DATA;
            dpkt_d  = {DATA_WRITE_LINE, idx_s, way_q, resp_data_s};
          end else begin
            state_d = S_UC_RET;
            dpkt_d  = {DATA_UC_RETURN, idx_s, way_q,
                       {(block_width_p-dword_width_p){1'b0}}, resp_data_s[dword_width_p-1:0]};
          end
        end else begin
          state_d = S_MEM_RESP;
        end
      end
      S_FILL_DATA: begin
        if (dpkt_hs_s) begin
          state_d  = S_FILL_TAG;
          dpkt_v_d = 1'b0;
          tpkt_v_d = 1'b1;
          tpkt_d   = {TAG_SET, idx_s, way_q, fill_state_s, tag_s};
        end else begin
          state_d = S_FILL_DATA;
        end
      end
      S_FILL_TAG: begin
        if (tpkt_hs_s) begin
          state_d  = S_FILL_STAT;
          tpkt_v_d = 1'b0;
          spkt_v_d = 1'b1;
          spkt_d   = {STAT_SET_LRU, idx_s, way_q};
        end else begin
          state_d = S_FILL_TAG;
        end
      end
      S_FILL_STAT: begin
        if (spkt_hs_s) begin
          state_d    = S_COMPLETE;
          spkt_v_d   = 1'b0;
          complete_d = 1'b1;
        end else begin
          state_d = S_FILL_STAT;
        end
      end
      S_UC_RET: begin
        if (dpkt_hs_s) begin
          state_d    = S_COMPLETE;
          dpkt_v_d   = 1'b0;
          complete_d = 1'b1;
        end else begin
          state_d = S_UC_RET;
        end
      end
      S_COMPLETE: begin
        state_d = S_IDLE;
      end
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
      S_WB_TAG: begin
        if (tpkt_hs_s) begin
          state_d  = S_WB_DATA;
          tpkt_v_d = 1'b0;
          rd_tag_d = 1'b1;
          dpkt_v_d = 1'b1;
          dpkt_d   = {DATA_READ_LINE, idx_s, way_q, {block_width_p{1'b0}}};
        end else begin
          state_d = S_WB_TAG;
        end
      end
      S_WB_DATA: begin
        if (rd_tag_q) begin
          wb_tag_d = tag_mem_i;
        end else begin
          wb_tag_d = wb_tag_q;
        end
        if (dpkt_hs_s) begin
          state_d   = S_WB_CMD;
          dpkt_v_d  = 1'b0;
          rd_data_d = 1'b1;
        end else begin
          state_d = S_WB_DATA;
        end
      end
      S_WB_CMD: begin
        // Line data is only valid the cycle after the read, so the command is raised then.
        if (rd_data_q) begin
          cmd_v_d = 1'b1;
          cmd_d   = {MEM_WRITE_LINE, wb_tag_q, idx_s, {offset_w_lp{1'b0}}, data_mem_i};
        end else if (cmd_hs_s) begin
          state_d = S_MEM_CMD;
          cmd_v_d = 1'b1;
          cmd_d   = miss_cmd_s;
        end else begin
          state_d = S_WB_CMD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cmd_hs_s && !yumi_s && (count_q != credits_lp)) begin
      count_d = count_q + cred_w_lp'(1);
    end else if (yumi_s && !cmd_hs_s && (count_q != {cred_w_lp{1'b0}})) begin
      count_d = count_q - cred_w_lp'(1);
    end else begin
      count_d = count_q;
    end
    ready_d = (state_d == S_IDLE) && (count_d != credits_lp);
  end

  // State, request context and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      req_type_q <= 2'b00;
      req_addr_q <= {paddr_width_p{1'b0}};
      req_data_q <= {dword_width_p{1'b0}};
      way_q      <= {lg_assoc_lp{1'b0}};
      cmd_q      <= {cmd_w_lp{1'b0}};
      cmd_v_q    <= 1'b0;
      dpkt_q     <= {dpkt_w_lp{1'b0}};
      dpkt_v_q   <= 1'b0;
      tpkt_q     <= {tpkt_w_lp{1'b0}};
      tpkt_v_q   <= 1'b0;
      spkt_q     <= {spkt_w_lp{1'b0}};
      spkt_v_q   <= 1'b0;
      complete_q <= 1'b0;
      ready_q    <= 1'b0;
      count_q    <= {cred_w_lp{1'b0}};
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
      wb_tag_q   <= {ptag_width_p{1'b0}};
      rd_tag_q   <= 1'b0;
      rd_data_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_type_q <= req_type_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      way_q      <= way_d;
      cmd_q      <= cmd_d;
      cmd_v_q    <= cmd_v_d;
      dpkt_q     <= dpkt_d;
      dpkt_v_q   <= dpkt_v_d;
      tpkt_q     <= tpkt_d;
      tpkt_v_q   <= tpkt_v_d;
      spkt_q     <= spkt_d;
      spkt_v_q   <= spkt_v_d;
      complete_q <= complete_d;
      ready_q    <= ready_d;
      count_q    <= count_d;
`ifdef BP_MISS_RESPONDER_WRITEBACK_EN
      wb_tag_q   <= wb_tag_d;
      rd_tag_q   <= rd_tag_d;
      rd_data_q  <= rd_data_d;
`endif
    end
  end

  assign cache_req_ready_o    = ready_q;
  assign cache_req_complete_o = complete_q;
  assign credits_full_o       = (count_q == credits_lp);
  assign credits_empty_o      = (count_q == {cred_w_lp{1'b0}});
  assign data_mem_pkt_o       = dpkt_q;
  assign data_mem_pkt_v_o     = dpkt_v_q;
  assign tag_mem_pkt_o        = tpkt_q;
  assign tag_mem_pkt_v_o      = tpkt_v_q;
  assign stat_mem_pkt_o       = spkt_q;
  assign stat_mem_pkt_v_o     = spkt_v_q;
  assign mem_cmd_o            = cmd_q;
  assign mem_cmd_v_o          = cmd_v_q;
  assign mem_resp_yumi_o      = yumi_s;

  bp_cache_miss_responder_chk #(.cred_width_p(cred_w_lp)) u_chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .yumi_i    (yumi_s),
    .count_i   (count_q));

endmodule
